// File: rtl/idu_decode.sv
// RV32E decode stage with a single-entry output register: 1-cycle latency, in_ready drops while a held entry is not taken.
// Optional IDU_EBREAK_EN: decodes ebreak as a legal system entry and raises ebreak_o while it is held.
module idu_decode #(
  parameter int XLEN   = 32,
  parameter int ALUC_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [31:0]       in_inst,
  output logic [3:0]        rs1_addr,
  output logic [3:0]        rs2_addr,
  input  logic [XLEN-1:0]   rs1_data,
  input  logic [XLEN-1:0]   rs2_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ALUC_W-1:0] out_aluc,
  output logic [XLEN-1:0]   out_num1,
  output logic [XLEN-1:0]   out_num2,
  output logic [XLEN-1:0]   out_imm,
  output logic [XLEN-1:0]   out_pc,
  output logic [3:0]        out_rd,
  output logic              out_wen,
  output logic [2:0]        out_funct3,
  output logic [2:0]        out_kind,
  output logic              out_ill,
  output logic              ebreak_o
);

  localparam logic [ALUC_W-1:0] ALU_ADD      = ALUC_W'(0);
  localparam logic [ALUC_W-1:0] ALU_SUB      = ALUC_W'(1);
  localparam logic [ALUC_W-1:0] ALU_SLL      = ALUC_W'(2);
  localparam logic [ALUC_W-1:0] ALU_SLTU     = ALUC_W'(3);
  localparam logic [ALUC_W-1:0] ALU_XOR      = ALUC_W'(4);
  localparam logic [ALUC_W-1:0] ALU_SRL      = ALUC_W'(5);
  localparam logic [ALUC_W-1:0] ALU_SRA      = ALUC_W'(6);
  localparam logic [ALUC_W-1:0] ALU_OR       = ALUC_W'(7);
  localparam logic [ALUC_W-1:0] ALU_AND      = ALUC_W'(8);
  localparam logic [ALUC_W-1:0] ALU_BEQ      = ALUC_W'(9);
  localparam logic [ALUC_W-1:0] ALU_BNE      = ALUC_W'(10);
  localparam logic [ALUC_W-1:0] ALU_BLT      = ALUC_W'(11);
  localparam logic [ALUC_W-1:0] ALU_BGE      = ALUC_W'(12);
  localparam logic [ALUC_W-1:0] ALU_BLTU     = ALUC_W'(13);
  localparam logic [ALUC_W-1:0] ALU_BGEU     = ALUC_W'(14);
  localparam logic [ALUC_W-1:0] ALU_ADD_LUI  = ALUC_W'(15);
  localparam logic [ALUC_W-1:0] ALU_ADD_JALR = ALUC_W'(16);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] F7_ALT    = 7'b0100000;

  typedef enum logic [2:0] {
    K_ALU    = 3'd0,
    K_LOAD   = 3'd1,
    K_STORE  = 3'd2,
    K_BRANCH = 3'd3,
    K_JAL    = 3'd4,
    K_JALR   = 3'd5,
    K_SYS    = 3'd6
  } kind_e;

  typedef struct packed {
    logic [ALUC_W-1:0] aluc;
    logic [XLEN-1:0]   num1;
    logic [XLEN-1:0]   num2;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   pc;
    logic [3:0]        rd;
    logic              wen;
    logic [2:0]        funct3;
    kind_e             kind;
    logic              ill;
  } entry_t;

  logic [6:0]        opcode;
  logic [6:0]        funct7;
  logic [2:0]        funct3;
  logic [4:0]        rd_f;
  logic [4:0]        rs1_f;
  logic [4:0]        rs2_f;
  logic [XLEN-1:0]   imm_i;
  logic [XLEN-1:0]   imm_s;
  logic [XLEN-1:0]   imm_b;
  logic [XLEN-1:0]   imm_u;
  logic [XLEN-1:0]   imm_j;
  logic [ALUC_W-1:0] alu_f3;
  logic              legal;
  logic              use_rd;
  logic              use_rs1;
  logic              use_rs2;
  logic              valid_q;
  entry_t            dec;
  entry_t            q;

  assign opcode   = in_inst[6:0];
  assign rd_f     = in_inst[11:7];
  assign funct3   = in_inst[14:12];
  assign rs1_f    = in_inst[19:15];
  assign rs2_f    = in_inst[24:20];
  assign funct7   = in_inst[31:25];
  assign rs1_addr = in_inst[18:15];
  assign rs2_addr = in_inst[23:20];

  assign imm_i = XLEN'($signed(in_inst[31:20]));
  assign imm_s = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
  assign imm_b = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({in_inst[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0}));

  // Shared funct3 map for R-type and I-ALU; slt reuses the signed-compare code.
  always_comb begin
    alu_f3 = ALU_ADD;
    case (funct3)
      3'b000:  alu_f3 = ALU_ADD;
      3'b001:  alu_f3 = ALU_SLL;
      3'b010:  alu_f3 = ALU_BLT;
      3'b011:  alu_f3 = ALU_SLTU;
      3'b100:  alu_f3 = ALU_XOR;
      3'b101:  alu_f3 = ALU_SRL;
      3'b110:  alu_f3 = ALU_OR;
      default: alu_f3 = ALU_AND;
    endcase
  end

`ifdef IDU_EBREAK_EN
  logic dec_ebreak;
  logic ebreak_q;
  assign dec_ebreak = legal && (opcode == OP_SYSTEM);
`endif

  always_comb begin
    dec        = '0;
    legal      = 1'b1;
    use_rd     = 1'b0;
    use_rs1    = 1'b0;
    use_rs2    = 1'b0;
    dec.pc     = in_pc;
    dec.funct3 = funct3;
    dec.kind   = K_ALU;
    dec.aluc   = ALU_ADD;
    case (opcode)
      OP_R: begin
        legal    = (funct7 == 7'd0) || (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101));
        {use_rd, use_rs1, use_rs2} = 3'b111;
        dec.wen  = 1'b1;
        dec.num1 = rs1_data;
        dec.num2 = rs2_data;
        dec.aluc = alu_f3;
        if (funct7[5] && funct3 == 3'b000) dec.aluc = ALU_SUB;
        if (funct7[5] && funct3 == 3'b101) dec.aluc = ALU_SRA;
      end
      OP_I: begin
        if (funct3 == 3'b001 || funct3 == 3'b101)
          legal = (funct7 == 7'd0) || (funct7 == F7_ALT);
        {use_rd, use_rs1} = 2'b11;
        dec.wen  = 1'b1;
        dec.num1 = rs1_data;
        dec.num2 = imm_i;
        dec.imm  = imm_i;
        dec.aluc = (funct3 == 3'b101 && in_inst[30]) ? ALU_SRA : alu_f3;
      end
      OP_LUI: begin
        use_rd   = 1'b1;
        dec.wen  = 1'b1;
        dec.aluc = ALU_ADD_LUI;
        dec.num2 = imm_u;
        dec.imm  = imm_u;
      end
      OP_AUIPC: begin
        use_rd   = 1'b1;
        dec.wen  = 1'b1;
        dec.num1 = in_pc;
        dec.num2 = imm_u;
        dec.imm  = imm_u;
      end
      OP_JAL: begin
        use_rd   = 1'b1;
        dec.wen  = 1'b1;
        dec.kind = K_JAL;
        dec.num1 = in_pc;
        dec.num2 = XLEN'(4);
        dec.imm  = imm_j;
      end
      OP_JALR: begin
        legal    = (funct3 == 3'b000);
        {use_rd, use_rs1} = 2'b11;
        dec.wen  = 1'b1;
        dec.kind = K_JALR;
        dec.aluc = ALU_ADD_JALR;
        dec.num1 = rs1_data;
        dec.num2 = imm_i;
        dec.imm  = imm_i;
      end
      OP_BRANCH: begin
        {use_rs1, use_rs2} = 2'b11;
        dec.kind = K_BRANCH;
        dec.num1 = rs1_data;
        dec.num2 = rs2_data;
        dec.imm  = imm_b;
        case (funct3)
          3'b000:  dec.aluc = ALU_BEQ;
          3'b001:  dec.aluc = ALU_BNE;
          3'b100:  dec.aluc = ALU_BLT;
          3'b101:  dec.aluc = ALU_BGE;
          3'b110:  dec.aluc = ALU_BLTU;
          3'b111:  dec.aluc = ALU_BGEU;
          default: legal    = 1'b0;
        endcase
      end
      OP_LOAD: begin
        {use_rd, use_rs1} = 2'b11;
        dec.wen  = 1'b1;
        dec.kind = K_LOAD;
        dec.num1 = rs1_data;
        dec.num2 = imm_i;
        dec.imm  = imm_i;
      end
      OP_STORE: begin
        {use_rs1, use_rs2} = 2'b11;
        dec.kind = K_STORE;
        dec.num1 = rs1_data;
        dec.num2 = imm_s;
        dec.imm  = imm_s;
      end
      OP_SYSTEM: begin
        dec.kind = K_SYS;
`ifdef IDU_EBREAK_EN
        legal    = (in_inst == 32'h0010_0073);
`else
        legal    = 1'b0;
`endif
      end
      default: legal = 1'b0;
    endcase

    // RV32E only has x0..x15, so bit 4 of any index in use is an encoding error.
    if ((use_rd && rd_f[4]) || (use_rs1 && rs1_f[4]) || (use_rs2 && rs2_f[4]))
      legal = 1'b0;
    dec.rd = use_rd ? rd_f[3:0] : 4'd0;
    if (rd_f == 5'd0)
      dec.wen = 1'b0;

    if (!legal) begin
      dec.aluc = ALU_ADD;
      dec.num1 = '0;
      dec.num2 = '0;
      dec.imm  = '0;
      dec.rd   = 4'd0;
      dec.wen  = 1'b0;
      dec.kind = K_ALU;
      dec.ill  = 1'b1;
    end
  end

  assign in_ready = !valid_q || out_ready;

  // flush wins over capture; a beat handshaken in the flush cycle is lost by design.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      q       <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (in_valid && in_ready) begin
      valid_q <= 1'b1;
      q       <= dec;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

`ifdef IDU_EBREAK_EN
  always_ff @(posedge clk) begin
    if (!rst_n)
      ebreak_q <= 1'b0;
    else if (!flush && in_valid && in_ready)
      ebreak_q <= dec_ebreak;
  end
  assign ebreak_o = valid_q && ebreak_q;
`else
  assign ebreak_o = 1'b0;
`endif

  assign out_valid  = valid_q;
  assign out_aluc   = q.aluc;
  assign out_num1   = q.num1;
  assign out_num2   = q.num2;
  assign out_imm    = q.imm;
  assign out_pc     = q.pc;
  assign out_rd     = q.rd;
  assign out_wen    = q.wen;
  assign out_funct3 = q.funct3;
  assign out_kind   = q.kind;
  assign out_ill    = q.ill;

endmodule

// File: tb/tb_idu_decode.sv
// Table-driven bench for idu_decode with a scoreboard queue of expected entries.
`timescale 1ns/1ps
module tb_idu_decode;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_inst;
  logic [3:0]  rs1_addr;
  logic [3:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_aluc;
  logic [31:0] out_num1;
  logic [31:0] out_num2;
  logic [31:0] out_imm;
  logic [31:0] out_pc;
  logic [3:0]  out_rd;
  logic        out_wen;
  logic [2:0]  out_funct3;
  logic [2:0]  out_kind;
  logic        out_ill;
  logic        ebreak_o;

  always #5 clk = ~clk;

  idu_decode #(.XLEN(32), .ALUC_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_inst(in_inst), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_aluc(out_aluc),
    .out_num1(out_num1), .out_num2(out_num2), .out_imm(out_imm), .out_pc(out_pc),
    .out_rd(out_rd), .out_wen(out_wen), .out_funct3(out_funct3), .out_kind(out_kind),
    .out_ill(out_ill), .ebreak_o(ebreak_o)
  );

  typedef struct {
    logic [31:0] inst, pc, r1, r2, num1, num2, imm;
    logic [4:0]  aluc;
    logic [3:0]  rd;
    logic        wen;
    logic [2:0]  kind;
    logic        ill;
    logic [2:0]  f3;
    logic        ebk;
  } vec_t;

  localparam logic [31:0] P = 32'h8000_0010;
  localparam logic [31:0] A = 32'h0000_0005;
  localparam logic [31:0] B = 32'h0000_0007;

  vec_t tbl[$];
  vec_t exp_q[$];
  vec_t cur;
  vec_t stall_v;
  int   total = 0;
  int   bad   = 0;
  int   nout  = 0;

  function automatic vec_t mk(logic [31:0] inst, logic [4:0] aluc, logic [31:0] n1, logic [31:0] n2,
                              logic [31:0] imm, logic [3:0] rd, logic wen, logic [2:0] kind, logic [2:0] f3);
    vec_t v;
    v.inst = inst; v.pc = P; v.r1 = A; v.r2 = B;
    v.aluc = aluc; v.num1 = n1; v.num2 = n2; v.imm = imm; v.rd = rd; v.wen = wen;
    v.kind = kind; v.ill = 1'b0; v.f3 = f3; v.ebk = 1'b0;
    return v;
  endfunction

  function automatic vec_t mk_ill(logic [31:0] inst, logic [2:0] f3);
    vec_t v;
    v = mk(inst, 5'd0, 32'd0, 32'd0, 32'd0, 4'd0, 1'b0, 3'd0, f3);
    v.ill = 1'b1;
    return v;
  endfunction

  task automatic chk(string nm, int id, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s #%0d: got %h want %h", nm, id, act, req);
    end
  endtask

  task automatic cmp_out(vec_t e, int id);
    chk("aluc",   id, 32'(out_aluc),   32'(e.aluc));
    chk("num1",   id, out_num1,        e.num1);
    chk("num2",   id, out_num2,        e.num2);
    chk("imm",    id, out_imm,         e.imm);
    chk("pc",     id, out_pc,          e.pc);
    chk("rd",     id, 32'(out_rd),     32'(e.rd));
    chk("wen",    id, 32'(out_wen),    32'(e.wen));
    chk("funct3", id, 32'(out_funct3), 32'(e.f3));
    chk("kind",   id, 32'(out_kind),   32'(e.kind));
    chk("ill",    id, 32'(out_ill),    32'(e.ill));
    chk("ebreak", id, 32'(ebreak_o),   32'(e.ebk));
  endtask

  task automatic check_zero(int id);
    chk("rst_valid",  id, 32'(out_valid),  0);
    chk("rst_aluc",   id, 32'(out_aluc),   0);
    chk("rst_num1",   id, out_num1,        0);
    chk("rst_num2",   id, out_num2,        0);
    chk("rst_imm",    id, out_imm,         0);
    chk("rst_pc",     id, out_pc,          0);
    chk("rst_rd",     id, 32'(out_rd),     0);
    chk("rst_wen",    id, 32'(out_wen),    0);
    chk("rst_funct3", id, 32'(out_funct3), 0);
    chk("rst_kind",   id, 32'(out_kind),   0);
    chk("rst_ill",    id, 32'(out_ill),    0);
    chk("rst_ebreak", id, 32'(ebreak_o),   0);
    chk("rst_in_ready", id, 32'(in_ready), 1);
  endtask

  task automatic drive(vec_t v, logic vld);
    cur      = v;
    in_inst  = v.inst;
    in_pc    = v.pc;
    rs1_data = v.r1;
    rs2_data = v.r2;
    in_valid = vld;
  endtask

  // Called at a negedge with inputs set; scores the handshakes of the coming posedge.
  task automatic step();
    #1;
    if (rst_n && !flush && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out", nout, 1, 0);
      end else begin
        cmp_out(exp_q.pop_front(), nout);
      end
      nout++;
    end
    if (rst_n && !flush && in_valid && in_ready)
      exp_q.push_back(cur);
    @(negedge clk);
  endtask

  task automatic drain(int id);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int n = 0; n < 8 && (exp_q.size() != 0 || out_valid); n++)
      step();
    chk("drain_empty", id, exp_q.size(), 0);
    chk("drain_valid", id, 32'(out_valid), 0);
    chk("drain_ebreak", id, 32'(ebreak_o), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t eb;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    in_inst = '0; in_pc = '0; rs1_data = '0; rs2_data = '0;

    tbl.push_back(mk(32'h0020_81B3, 5'd0,  A, B, 32'd0, 4'd3, 1'b1, 3'd0, 3'd0));             // add x3
    tbl.push_back(mk(32'h4020_81B3, 5'd1,  A, B, 32'd0, 4'd3, 1'b1, 3'd0, 3'd0));             // sub
    tbl.push_back(mk(32'h1234_52B7, 5'd15, 32'd0, 32'h1234_5000, 32'h1234_5000, 4'd5, 1'b1, 3'd0, 3'd5));
    tbl.push_back(mk(32'hFFF0_8313, 5'd0,  A, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd6, 1'b1, 3'd0, 3'd0));
    tbl.push_back(mk(32'h4030_D393, 5'd6,  A, 32'h0000_0403, 32'h0000_0403, 4'd7, 1'b1, 3'd0, 3'd5));
    tbl.push_back(mk_ill(32'h0230_9393, 3'd1));                                                 // bad slli funct7
    tbl.push_back(mk(32'hFFC1_2403, 5'd0,  A, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 4'd8, 1'b1, 3'd1, 3'd2));
    tbl.push_back(mk(32'h0020_A623, 5'd0,  A, 32'd12, 32'd12, 4'd0, 1'b0, 3'd2, 3'd2));
    tbl.push_back(mk(32'h0100_00EF, 5'd0,  P, 32'd4, 32'd16, 4'd1, 1'b1, 3'd4, 3'd0));
    tbl.push_back(mk(32'h0042_80E7, 5'd16, A, 32'd4, 32'd4, 4'd1, 1'b1, 3'd5, 3'd0));
    tbl.push_back(mk_ill(32'h0042_90E7, 3'd1));                                                 // jalr funct3!=0
    tbl.push_back(mk(32'h0000_1217, 5'd0,  P, 32'h0000_1000, 32'h0000_1000, 4'd4, 1'b1, 3'd0, 3'd1));
    tbl.push_back(mk_ill(32'h0020_88B3, 3'd0));                                                 // rd=x17
    tbl.push_back(mk(32'h0000_2033, 5'd11, A, B, 32'd0, 4'd0, 1'b0, 3'd0, 3'd2));               // rd=x0
    tbl.push_back(mk_ill(32'h0000_2063, 3'd2));                                                 // branch f3=010
    tbl.push_back(mk(32'hFE20_CEE3, 5'd11, A, B, 32'hFFFF_FFFC, 4'd0, 1'b0, 3'd3, 3'd4));       // blt -4
    tbl.push_back(mk_ill(32'h0000_000B, 3'd0));                                                 // unknown opcode
    tbl.push_back(mk(32'h0020_D1B3, 5'd5,  A, B, 32'd0, 4'd3, 1'b1, 3'd0, 3'd5));               // srl
    tbl.push_back(mk_ill(32'h0100_81B3, 3'd0));                                                 // rs2=x16
    tbl.push_back(mk_ill(32'h0000_0073, 3'd0));                                                 // ecall
`ifdef IDU_EBREAK_EN
    eb = mk(32'h0010_0073, 5'd0, 32'd0, 32'd0, 32'd0, 4'd0, 1'b0, 3'd6, 3'd0);
    eb.ebk = 1'b1;
`else
    eb = mk_ill(32'h0010_0073, 3'd0);
`endif
    tbl.push_back(eb);
    stall_v = mk(32'h0020_9463, 5'd10, A, B, 32'd8, 4'd0, 1'b0, 3'd3, 3'd1);                   // bne +8

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_zero(0);
    @(negedge clk);

    // First entry appears one cycle after acceptance, then stream the rest back-to-back.
    out_ready = 1'b1;
    drive(tbl[0], 1'b1);
    step();
    chk("latency_valid", 0, 32'(out_valid), 1);
    for (int i = 1; i < tbl.size(); i++) begin
      drive(tbl[i], 1'b1);
      chk("in_ready_stream", i, 32'(in_ready), 1);
      step();
      chk("rs1_addr", i, 32'(rs1_addr), 32'(cur.inst[18:15]));
      chk("rs2_addr", i, 32'(rs2_addr), 32'(cur.inst[23:20]));
    end
    drain(1);

    // Stall: held entry must stay stable and block the next input.
    drive(stall_v, 1'b1);
    step();
    out_ready = 1'b0;
    drive(tbl[0], 1'b1);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall_in_ready", k, 32'(in_ready), 0);
      chk("stall_valid", k, 32'(out_valid), 1);
      chk("stall_depth", k, exp_q.size(), 1);
      cmp_out(stall_v, 100 + k);
    end
    out_ready = 1'b1;
    step();
    drain(2);

    // Flush of a held entry with a simultaneous input beat.
    drive(tbl[0], 1'b1);
    step();
    out_ready = 1'b0;
    drive(tbl[1], 1'b1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    exp_q.delete();
    chk("flush_valid", 0, 32'(out_valid), 0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    chk("flush_nocap", 0, 32'(out_valid), 0);

    // Flush with an empty stage drops the beat that handshakes.
    drive(tbl[2], 1'b1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_drop", 1, 32'(out_valid), 0);

    // Reset in the middle of a stall clears everything.
    drive(tbl[2], 1'b1);
    step();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    step();
    chk("pre_rst_valid", 0, 32'(out_valid), 1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    exp_q.delete();
    #1;
    check_zero(1);
    @(negedge clk);

    // Ebreak alone, checked while held.
    out_ready = 1'b1;
    drive(eb, 1'b1);
    step();
    in_valid = 1'b0;
    out_ready = 1'b0;
    #1;
    cmp_out(eb, 200);
    @(negedge clk);
    drain(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
